bcd_encoder_debounced: RTL and testbench
========================================

# bcd_encoder_debounced

Sequential, parametrised successor of the one-hot 10-to-BCD encoder. Samples an N-line one-hot input (keypad / selector lines), requires the pattern to be stable for a programmable number of clock cycles, then registers its binary code and emits a one-cycle valid strobe. It sits between raw switch/keypad lines and the BCD display and counter logic of the lab designs.

## Interface
- N, default 10: number of one-hot input lines, 2..64.
- W, default 4: output code width, equals $clog2(N).
- STABLE_CYCLES, default 4: consecutive equal samples required before acceptance, 1..255.
- clk  input  1  rising-edge system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- X  input  N  one-hot input lines. Bit i encodes value i. Externally synchronised to clk.
- Y  output  W  last accepted code. Values ≥ N are never produced.
- valid  output  1  one-cycle pulse when a new code is loaded into Y.
- active  output  1  high while the accepted pattern is still present (HELD).
- err  output  1  one-cycle pulse on a rejected multi-hot pattern. Tied 0 when ENC_MULTI_ERR_EN is undefined.

## Operation
- Internal registers: sample x_q[N-1:0], counter cnt[$clog2(STABLE_CYCLES+1)-1:0], state.
- States: IDLE, SETTLE, HELD, REJECT.
- IDLE: x_q==0, active=0. A sampled nonzero X loads x_q, sets cnt=0 and moves to SETTLE.
- SETTLE: on each edge where X==x_q, cnt increments. On the edge where cnt==STABLE_CYCLES-1 and X==x_q, the pattern is accepted:
  - Normal case: Y<=encode(x_q), valid<=1, go to HELD.
  - Multi-hot with the macro defined: err<=1, Y unchanged, go to REJECT.
- SETTLE, X changes: if X≠x_q and X nonzero, x_q<=X, cnt<=0 and the state stays SETTLE. If X==0, go to IDLE with no strobe.
- HELD: active=1 while X==x_q.
  - X==0: go to IDLE.
  - X different and nonzero: go to SETTLE with the new x_q and cnt=0.
- REJECT: active=0. The same exits as HELD apply.
- Y holds the last accepted code through IDLE, SETTLE and REJECT. Y changes only together with valid.
- encode() rule: the highest set index wins. Multi-hot means popcount(x_q)>1.

## Timing
- Reset: after the rst edge, Y=0, valid=0, active=0, err=0, x_q=0, cnt=0, state=IDLE. rst takes priority over every other event, including an acceptance on the same edge.
- Latency: edge k is the first edge that samples a new nonzero X, with X held constant afterwards.
  - valid/err are registered high after edge k+STABLE_CYCLES-1, for exactly one cycle.
  - Y is updated on the same edge as valid. active rises with valid.
- STABLE_CYCLES=1: acceptance happens on the edge after the first sample.
- Reset mid-SETTLE or mid-HELD: no strobe is produced, and Y returns to 0.
- A change of X on the acceptance edge itself counts as a change: no acceptance, the counter restarts.
- At most one of valid/err is high in any cycle.

## Configuration
- ENC_MULTI_ERR_EN defined: multi-hot patterns are rejected. The block produces an err pulse, enters REJECT, and leaves Y unchanged.
- ENC_MULTI_ERR_EN undefined: multi-hot patterns are accepted using the highest-index priority. err is held at 0 and REJECT is unreachable.

## Structure
- Package enc_pkg holds:
  - the state enum enc_state_t (IDLE, SETTLE, HELD, REJECT);
  - constants MAX_N=64 and MAX_STABLE=255.
- Sub-module onehot_prio_enc: combinational, parameters N and W. It takes x_q and returns the code and the multi flag. The FSM, counter and output registers stay in the top module.

## Test plan
- Reset: drive rst=1 for 2 cycles with X=10'h004 → Y=0, valid=0, active=0, err=0 throughout.
- Basic accept: with STABLE_CYCLES=4, hold X=10'b0010000000 from edge 0 → valid pulses once after edge 3, Y=7, active=1 until X=0 is sampled.
- Bounce: X toggles between 10'h008 and 0 every 2 cycles for 12 cycles, then holds 10'h008 → exactly one valid, Y=3, only after 4 stable samples.
- Direct change: in HELD with Y=5, change X to 10'h200 → active drops, then after 4 samples valid pulses and Y=9. No strobe occurs in between.
- Multi-hot, macro defined: X=10'b0000100100 held → err pulse after edge 3, Y keeps its prior value, no valid. Macro undefined → valid pulse with Y=5.
- Reset mid-SETTLE: assert rst on the edge where cnt==2 → no valid, Y=0. After release, the held X is re-accepted 4 samples later.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and limits for the debounced one-hot to binary encoder.
package enc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HELD,
      REJECT
   } enc_state_t;

   localparam int MAX_N      = 64;
   localparam int MAX_STABLE = 255;

endpackage

// File: rtl/onehot_prio_enc.sv
// Combinational one-hot encoder: the highest set line wins; multi flags more than one set line.
module onehot_prio_enc
   import enc_pkg::*;
#(
   parameter int N = 10,
   parameter int W = 4
) (
   input  logic [N-1:0] x,
   output logic [W-1:0] code,
   output logic         multi
);

   logic seen;

   // Scan upward so later (higher) lines overwrite the code, and flag any second hit.
   always_comb begin
      code  = '0;
      multi = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i < MAX_N && x[i]) begin
            multi = multi | seen;
            seen  = 1'b1;
            code  = W'(i);
         end
      end
   end

endmodule

// File: rtl/bcd_encoder_debounced.sv
// Debounced one-hot encoder: a pattern must be stable for STABLE_CYCLES samples before Y/valid update.
// Define ENC_MULTI_ERR_EN to reject multi-hot patterns with an err pulse instead of encoding them.
module bcd_encoder_debounced
   import enc_pkg::*;
#(
   parameter int N             = 10,
   parameter int W             = $clog2(N),
   parameter int STABLE_CYCLES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] X,
   output logic [W-1:0] Y,
   output logic         valid,
   output logic         active,
   output logic         err
);

   localparam int StableEff = (STABLE_CYCLES > MAX_STABLE) ? MAX_STABLE : STABLE_CYCLES;
   localparam int CW        = $clog2(StableEff + 1);
   // The first sample already counts, so acceptance comes StableEff-1 edges later (one edge minimum).
   localparam int AcceptAt  = (StableEff >= 2) ? StableEff - 2 : 0;
   localparam logic [CW-1:0] AcceptCnt = CW'(AcceptAt);

`ifdef ENC_MULTI_ERR_EN
   localparam bit MultiErrEn = 1'b1;
`else
   localparam bit MultiErrEn = 1'b0;
`endif

   enc_state_t    state, state_d;
   logic [N-1:0]  x_q, x_q_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [W-1:0]  y_d;
   logic          valid_d, err_d;
   logic [W-1:0]  code;
   logic          multi;

   onehot_prio_enc #(
      .N(N),
      .W(W)
   ) u_enc (
      .x    (x_q),
      .code (code),
      .multi(multi)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         x_q   <= '0;
         cnt   <= '0;
         Y     <= '0;
         valid <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_d;
         x_q   <= x_q_d;
         cnt   <= cnt_d;
         Y     <= y_d;
         valid <= valid_d;
         err   <= err_d;
      end
   end

   // Any change of X, even on the acceptance edge, restarts settling with the new pattern.
   always_comb begin
      state_d = state;
      x_q_d   = x_q;
      cnt_d   = cnt;
      y_d     = Y;
      valid_d = 1'b0;
      err_d   = 1'b0;
      case (state)
         IDLE: begin
            if (X != '0) begin
               x_q_d   = X;
               cnt_d   = '0;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (X == '0) begin
               x_q_d   = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (X != x_q) begin
               x_q_d = X;
               cnt_d = '0;
            end else if (cnt == AcceptCnt) begin
               cnt_d = '0;
               if (MultiErrEn && multi) begin
                  err_d   = 1'b1;
                  state_d = REJECT;
               end else begin
                  y_d     = code;
                  valid_d = 1'b1;
                  state_d = HELD;
               end
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         HELD, REJECT: begin
            if (X == '0) begin
               x_q_d   = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (X != x_q) begin
               x_q_d   = X;
               cnt_d   = '0;
               state_d = SETTLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign active = (state == HELD);

endmodule

// File: tb/tb_bcd_encoder_debounced.sv
// Self-checking bench for bcd_encoder_debounced: per-edge vector table plus reset and STABLE_CYCLES=1 sequences.
module tb_bcd_encoder_debounced;

`ifdef ENC_MULTI_ERR_EN
   localparam bit MultiErr = 1'b1;
`else
   localparam bit MultiErr = 1'b0;
`endif

   typedef struct {
      logic [9:0] x;
      logic [3:0] y;
      logic       valid;
      logic       active;
      logic       err;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] X   = '0;
   logic [3:0] Y;
   logic       valid, active, err;

   logic [3:0] X1 = '0;
   logic [1:0] Y1;
   logic       valid1, active1, err1;

   int tests  = 0;
   int failed = 0;
   vec_t vecs[$];

   bcd_encoder_debounced #(.N(10), .W(4), .STABLE_CYCLES(4)) u_dut (
      .clk(clk), .rst(rst), .X(X), .Y(Y), .valid(valid), .active(active), .err(err)
   );

   bcd_encoder_debounced #(.N(4), .W(2), .STABLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .X(X1), .Y(Y1), .valid(valid1), .active(active1), .err(err1)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [9:0] x, input logic r);
      @(negedge clk);
      X   = x;
      rst = r;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] ey, input logic ev,
                              input logic ea, input logic ee);
      tests++;
      if (Y !== ey || valid !== ev || active !== ea || err !== ee) begin
         failed++;
         $display("[TB] FAIL %s: got Y=%0d valid=%b active=%b err=%b, want Y=%0d valid=%b active=%b err=%b",
                  name, Y, valid, active, err, ey, ev, ea, ee);
      end
   endtask

   function automatic void addVec(input logic [9:0] x, input logic [3:0] y, input logic v,
                                  input logic a, input logic e);
      vec_t t;
      t.x = x; t.y = y; t.valid = v; t.active = a; t.err = e;
      vecs.push_back(t);
   endfunction

   initial begin
      logic [3:0] ym;
      ym = MultiErr ? 4'd2 : 4'd5;

      // Basic accept of line 7, then release.
      addVec(10'h080, 4'd0, 0, 0, 0);
      addVec(10'h080, 4'd0, 0, 0, 0);
      addVec(10'h080, 4'd0, 0, 0, 0);
      addVec(10'h080, 4'd7, 1, 1, 0);
      addVec(10'h080, 4'd7, 0, 1, 0);
      addVec(10'h000, 4'd7, 0, 0, 0);
      // Bouncing line 3, then held.
      for (int b = 0; b < 12; b++)
         addVec(((b % 4) < 2) ? 10'h008 : 10'h000, 4'd7, 0, 0, 0);
      addVec(10'h008, 4'd7, 0, 0, 0);
      addVec(10'h008, 4'd7, 0, 0, 0);
      addVec(10'h008, 4'd7, 0, 0, 0);
      addVec(10'h008, 4'd3, 1, 1, 0);
      addVec(10'h008, 4'd3, 0, 1, 0);
      // Direct change in HELD: 3 -> 5 -> 9.
      addVec(10'h020, 4'd3, 0, 0, 0);
      addVec(10'h020, 4'd3, 0, 0, 0);
      addVec(10'h020, 4'd3, 0, 0, 0);
      addVec(10'h020, 4'd5, 1, 1, 0);
      addVec(10'h020, 4'd5, 0, 1, 0);
      addVec(10'h200, 4'd5, 0, 0, 0);
      addVec(10'h200, 4'd5, 0, 0, 0);
      addVec(10'h200, 4'd5, 0, 0, 0);
      addVec(10'h200, 4'd9, 1, 1, 0);
      addVec(10'h200, 4'd9, 0, 1, 0);
      // Change on the would-be acceptance edge restarts settling.
      addVec(10'h002, 4'd9, 0, 0, 0);
      addVec(10'h002, 4'd9, 0, 0, 0);
      addVec(10'h002, 4'd9, 0, 0, 0);
      addVec(10'h004, 4'd9, 0, 0, 0);
      addVec(10'h004, 4'd9, 0, 0, 0);
      addVec(10'h004, 4'd9, 0, 0, 0);
      addVec(10'h004, 4'd2, 1, 1, 0);
      // Multi-hot lines 2 and 5.
      addVec(10'h024, 4'd2, 0, 0, 0);
      addVec(10'h024, 4'd2, 0, 0, 0);
      addVec(10'h024, 4'd2, 0, 0, 0);
      addVec(10'h024, ym, !MultiErr, !MultiErr, MultiErr);
      addVec(10'h024, ym, 0, !MultiErr, 0);
      addVec(10'h000, ym, 0, 0, 0);

      // Reset held with a live input.
      applyStimulus(10'h004, 1'b1);
      checkOutput("reset_edge0", 4'd0, 0, 0, 0);
      applyStimulus(10'h004, 1'b1);
      checkOutput("reset_edge1", 4'd0, 0, 0, 0);
      applyStimulus(10'h000, 1'b0);
      checkOutput("reset_release", 4'd0, 0, 0, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].x, 1'b0);
         checkOutput($sformatf("vec%0d", i), vecs[i].y, vecs[i].valid, vecs[i].active, vecs[i].err);
      end

      // Reset on the acceptance edge (cnt==2), then re-accept after release.
      applyStimulus(10'h040, 1'b0);
      applyStimulus(10'h040, 1'b0);
      applyStimulus(10'h040, 1'b0);
      checkOutput("settle_pre_reset", ym, 0, 0, 0);
      applyStimulus(10'h040, 1'b1);
      checkOutput("reset_mid_settle", 4'd0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(10'h040, 1'b0);
         checkOutput($sformatf("resettle%0d", k), 4'd0, 0, 0, 0);
      end
      applyStimulus(10'h040, 1'b0);
      checkOutput("reaccept", 4'd6, 1, 1, 0);

      // Reset while HELD clears Y with no strobe.
      applyStimulus(10'h040, 1'b1);
      checkOutput("reset_mid_held", 4'd0, 0, 0, 0);
      applyStimulus(10'h000, 1'b0);
      checkOutput("after_held_reset", 4'd0, 0, 0, 0);

      // STABLE_CYCLES=1 instance accepts on the edge after the first sample.
      @(negedge clk);
      X1 = 4'b0100;
      @(posedge clk);
      #1;
      tests++;
      if (Y1 !== 2'd0 || valid1 !== 1'b0) begin
         failed++;
         $display("[TB] FAIL sc1_first: got Y=%0d valid=%b, want Y=0 valid=0", Y1, valid1);
      end
      @(posedge clk);
      #1;
      tests++;
      if (Y1 !== 2'd2 || valid1 !== 1'b1 || active1 !== 1'b1 || err1 !== 1'b0) begin
         failed++;
         $display("[TB] FAIL sc1_accept: got Y=%0d valid=%b active=%b err=%b, want Y=2 valid=1 active=1 err=0",
                  Y1, valid1, active1, err1);
      end
      @(posedge clk);
      #1;
      tests++;
      if (Y1 !== 2'd2 || valid1 !== 1'b0 || active1 !== 1'b1) begin
         failed++;
         $display("[TB] FAIL sc1_held: got Y=%0d valid=%b active=%b, want Y=2 valid=0 active=1", Y1, valid1, active1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
